// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, parity constants,
// minimum prescale and the 3-sample majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   MIN_PRESCALE = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote for the UART receiver.
// vote_vld pulses on the third sample cycle; vote is the majority of the
// two registered samples and the current line value.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      line,
  output logic                      vote,
  output logic                      vote_vld
);

  localparam int PW = PRESCALE_WIDTH;

  logic [PW-1:0] cnt;
  logic [PW-1:0] half;
  logic          samp_a;
  logic          samp_b;

  assign half     = prescale >> 1;
  assign vote_vld = en && (cnt == half + PW'(1));
  assign vote     = maj3(samp_a, samp_b, line);

  // Edge counter wraps every prescale cycles; first two samples are held.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt    <= '0;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (!en) begin
      cnt <= '0;
    end else begin
      cnt <= (cnt == prescale - PW'(1)) ? '0 : cnt + PW'(1);
      if (cnt == half - PW'(1)) samp_a <= line;
      if (cnt == half)          samp_b <= line;
    end
  end

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with parity, 1/2 stop bits, valid/ready output register
// and overrun reporting. Optional break detection under the macro
// UART_RX_BREAK_DET_EN (adds the brk port).
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STP_2,
  output logic [DATA_WIDTH-1:0]     P_data,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      par_err,
  output logic                      frm_err,
  output logic                      overrun
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                      brk
`endif
);

  localparam int BW = $clog2(DATA_WIDTH);

  logic                      rx_s1, rx_s2, rx_prev;
  logic [1:0]                sync_ok;
  rx_state_e                 state;
  logic [BW-1:0]             bit_idx;
  logic [DATA_WIDTH-1:0]     shreg;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      par_en_q, par_typ_q, stp2_q, par_bit_q, stop_any0;
  logic                      vote, vote_vld;
  logic                      fall, last_stop, par_now, frm_now, idle_ok;

  uart_rx_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state != ST_IDLE),
    .prescale (prescale_q),
    .line     (rx_s2),
    .vote     (vote),
    .vote_vld (vote_vld)
  );

  // rx_prev only tracks real line samples, so the synchroniser's reset
  // value can never fake a high-then-low edge after reset.
  assign fall      = rx_prev & ~rx_s2;
  assign last_stop = !stp2_q || (bit_idx == BW'(1));
  assign par_now   = par_en_q && ((^shreg ^ par_typ_q) != par_bit_q);
  assign frm_now   = stop_any0 | ~vote;

`ifdef UART_RX_BREAK_DET_EN
  logic stop_any1, wait_high, is_brk;
  assign is_brk  = (shreg == '0) && !(par_en_q && par_bit_q) && !(stop_any1 | vote);
  assign idle_ok = !wait_high;
`else
  assign idle_ok = 1'b1;
`endif

  // Synchroniser, frame FSM and output register. Each bit is consumed at
  // its vote, so the final stop bit releases the FSM mid-bit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b0;
      sync_ok    <= 2'b00;
      state      <= ST_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      prescale_q <= PRESCALE_WIDTH'(MIN_PRESCALE);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      stp2_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_any0  <= 1'b0;
      P_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk        <= 1'b0;
      stop_any1  <= 1'b0;
      wait_high  <= 1'b0;
`endif
    end else begin
      rx_s1   <= RX_IN;
      rx_s2   <= rx_s1;
      sync_ok <= {sync_ok[0], 1'b1};
      rx_prev <= rx_s2 & sync_ok[1];
      overrun <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk     <= 1'b0;
`endif
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
          if (rx_s2) wait_high <= 1'b0;
`endif
          if (fall && idle_ok) begin
            state      <= ST_START;
            prescale_q <= prescale;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            stp2_q     <= STP_2;
            bit_idx    <= '0;
            par_bit_q  <= 1'b0;
            stop_any0  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            stop_any1  <= 1'b0;
`endif
          end
        end
        ST_START: if (vote_vld) state <= vote ? ST_IDLE : ST_DATA;
        ST_DATA: if (vote_vld) begin
          shreg <= {vote, shreg[DATA_WIDTH-1:1]};
          if (bit_idx == BW'(DATA_WIDTH - 1)) begin
            bit_idx <= '0;
            state   <= par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx <= bit_idx + BW'(1);
          end
        end
        ST_PARITY: if (vote_vld) begin
          par_bit_q <= vote;
          state     <= ST_STOP;
        end
        ST_STOP: if (vote_vld) begin
          stop_any0 <= frm_now;
`ifdef UART_RX_BREAK_DET_EN
          stop_any1 <= stop_any1 | vote;
`endif
          if (!last_stop) begin
            bit_idx <= BW'(1);
          end else begin
            state <= ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
            if (is_brk) begin
              brk       <= 1'b1;
              wait_high <= 1'b1;
            end else
`endif
            if (!data_valid || data_ready) begin
              P_data     <= shreg;
              par_err    <= par_now;
              frm_err    <= frm_now;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: a frame-level expectation queue plus a
// per-cycle compare process, and literal checks on selected frames.
module tb_uart_rx_ext;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       PAR_EN = 1'b0, PAR_TYP = 1'b0, STP_2 = 1'b0;
  logic [7:0] P_data;
  logic       data_valid, data_ready = 1'b1;
  logic       par_err, frm_err, overrun;
`ifdef UART_RX_BREAK_DET_EN
  logic       brk;
`endif

  int   checks = 0, errors = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic [7:0] last_d = 8'h00;
  logic       last_pe = 1'b0, last_fe = 1'b0;
  int   valid_cycles = 0, ovr_seen = 0, ovr_exp = 0, brk_seen = 0;
  bit   prev_valid = 1'b0, prev_hs = 1'b0, prev_ovr = 1'b0, prev_brk = 1'b0;

  uart_rx_ext dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STP_2      (STP_2),
    .P_data     (P_data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .par_err    (par_err),
    .frm_err    (frm_err),
    .overrun    (overrun)
`ifdef UART_RX_BREAK_DET_EN
    ,
    .brk        (brk)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Every new word must match the head of the expectation queue; a held
  // word must stay stable until it is handed off.
  always @(negedge CLK) begin
    if (!RST) begin
      prev_valid = 1'b0; prev_hs = 1'b0; prev_ovr = 1'b0; prev_brk = 1'b0;
    end else begin
      if (data_valid && (!prev_valid || prev_hs)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", int'(P_data), -1);
        end else begin
          cur = exp_q.pop_front();
          chk("word_data", int'(P_data), int'(cur.d));
          chk("word_par_err", int'(par_err), int'(cur.pe));
          chk("word_frm_err", int'(frm_err), int'(cur.fe));
        end
        last_d = P_data; last_pe = par_err; last_fe = frm_err;
      end else if (data_valid) begin
        chk("hold_data", int'(P_data), int'(last_d));
        chk("hold_par_err", int'(par_err), int'(last_pe));
        chk("hold_frm_err", int'(frm_err), int'(last_fe));
      end
      if (data_valid) valid_cycles++;
      if (overrun) begin
        ovr_seen++;
        chk("overrun_width", int'(prev_ovr), 0);
      end
`ifdef UART_RX_BREAK_DET_EN
      if (brk) begin
        brk_seen++;
        chk("brk_width", int'(prev_brk), 0);
      end
      prev_brk = brk;
`endif
      prev_valid = data_valid;
      prev_hs    = data_valid && data_ready;
      prev_ovr   = overrun;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic drive_bit(input logic v, input int n);
    RX_IN = v;
    idle(n);
  endtask

  // Serialises one frame under the current configuration. rdy_pulse raises
  // data_ready for exactly the cycle in which the final stop vote lands.
  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit st0,
                            input bit st1, input bit push, input bit rdy_pulse);
    int   p;
    logic pbit, last;
    exp_t e;
    p    = int'(prescale);
    pbit = (^d) ^ PAR_TYP;
    if (!par_ok) pbit = ~pbit;
    if (push) begin
      e.d  = d;
      e.pe = PAR_EN && !par_ok;
      e.fe = !st0 || (STP_2 && !st1);
      exp_q.push_back(e);
    end
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (PAR_EN) drive_bit(pbit, p);
    if (STP_2) begin
      drive_bit(st0, p);
      last = st1;
    end else begin
      last = st0;
    end
    RX_IN = last;
    for (int i = 1; i <= p; i++) begin
      @(posedge CLK); #1;
      if (rdy_pulse && i == p / 2 + 4) data_ready = 1'b1;
      if (rdy_pulse && i == p / 2 + 5) data_ready = 1'b0;
    end
    RX_IN = 1'b1;
  endtask

  int vc0, o0;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_P_data", int'(P_data), 0);
    chk("reset_valid", int'(data_valid), 0);
    chk("reset_flags", int'({par_err, frm_err, overrun}), 0);
    RST = 1'b1;
    idle(10);

    // Basic 8N1 frame at the minimum prescale.
    vc0 = valid_cycles;
    send_frame(8'hA5, 1, 1, 1, 1, 0);
    idle(20);
    chk("a5_data", int'(last_d), 8'hA5);
    chk("a5_flags", int'({last_pe, last_fe}), 0);
    chk("a5_valid_len", valid_cycles - vc0, 1);

    // Odd parity, wrong then correct parity bit; then even with wrong bit.
    prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send_frame(8'h3C, 0, 1, 1, 1, 0);
    idle(30);
    chk("par_bad_data", int'(last_d), 8'h3C);
    chk("par_bad_err", int'(last_pe), 1);
    send_frame(8'h3C, 1, 1, 1, 1, 0);
    idle(30);
    chk("par_ok_err", int'(last_pe), 0);
    PAR_TYP = 1'b0;
    send_frame(8'h07, 0, 1, 1, 1, 0);
    idle(30);
    chk("par_even_bad", int'(last_pe), 1);

    // Two stop bits: either stop bit low flags a framing error.
    prescale = 6'd8; PAR_EN = 1'b0; STP_2 = 1'b1;
    send_frame(8'h81, 1, 1, 0, 1, 0);
    idle(20);
    chk("stp2_second_low", int'(last_fe), 1);
    send_frame(8'h42, 1, 0, 1, 1, 0);
    send_frame(8'h24, 1, 1, 1, 1, 0);
    idle(20);
    chk("stp2_clean", int'({last_d, last_fe}), {8'h24, 1'b0});
    STP_2 = 1'b0;

    // Short low glitch is rejected; the next frame is received normally.
    prescale = 6'd16;
    vc0 = valid_cycles;
    drive_bit(1'b0, 2);
    RX_IN = 1'b1;
    idle(40);
    chk("glitch_no_word", valid_cycles - vc0, 0);
    send_frame(8'hC3, 1, 1, 1, 1, 0);
    idle(30);
    chk("post_glitch", int'(last_d), 8'hC3);

    // Back-to-back frames with the consumer stalled: second one dropped.
    prescale = 6'd8; data_ready = 1'b0;
    o0 = ovr_seen;
    send_frame(8'h11, 1, 1, 1, 1, 0);
    send_frame(8'h22, 1, 1, 1, 0, 0);
    idle(20);
    ovr_exp++;
    chk("ovr_held", int'(P_data), 8'h11);
    chk("ovr_once", ovr_seen - o0, 1);
    data_ready = 1'b1;
    idle(4);

    // Handshake coincides with completion: new word loads, no overrun.
    prescale = 6'd16; data_ready = 1'b0;
    o0 = ovr_seen;
    send_frame(8'h33, 1, 1, 1, 1, 0);
    send_frame(8'h22, 1, 1, 1, 1, 1);
    idle(30);
    chk("hs_new_word", int'(P_data), 8'h22);
    chk("hs_no_overrun", ovr_seen - o0, 0);
    data_ready = 1'b1;
    idle(4);

    // Reset in the middle of DATA with a word held.
    prescale = 6'd8; data_ready = 1'b0;
    send_frame(8'h77, 1, 1, 1, 1, 0);
    idle(20);
    drive_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 8);
    RX_IN = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_P_data", int'(P_data), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_flags", int'({par_err, frm_err, overrun}), 0);
    RST = 1'b1; data_ready = 1'b1;
    idle(24);
    RX_IN = 1'b1;
    idle(16);
    send_frame(8'h5A, 1, 1, 1, 1, 0);
    idle(20);
    chk("post_rst", int'(last_d), 8'h5A);

    // Line held low for 12 bit times.
    prescale = 6'd8;
`ifndef UART_RX_BREAK_DET_EN
    begin
      exp_t e;
      e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1;
      exp_q.push_back(e);
    end
`endif
    drive_bit(1'b0, 12 * 8);
    RX_IN = 1'b1;
    idle(30);
`ifdef UART_RX_BREAK_DET_EN
    chk("brk_count", brk_seen, 1);
`else
    chk("brk_frame", int'({last_d, last_fe}), {8'h00, 1'b1});
`endif
    send_frame(8'h96, 1, 1, 1, 1, 0);
    idle(20);
    chk("post_brk", int'(last_d), 8'h96);

    chk("queue_empty", exp_q.size(), 0);
    chk("overrun_total", ovr_seen, ovr_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
